// File: rtl/multicycle_control.sv
// Multicycle CPU control FSM: sequences fetch/decode/exec/mem/writeback per opcode class,
// with a memory-wait watchdog and sticky illegal/timeout traps.
module multicycle_control #(
  parameter bit          EXT_OPS   = 1'b1,
  parameter int unsigned TIMEOUT_W = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  opcode,
  input  logic        mem_ready,
  output logic [10:0] signals,
  output logic        fetch_req,
  output logic        ir_write,
  output logic        pc_write,
  output logic        retire,
  output logic        illegal,
  output logic        timeout,
  output logic [2:0]  state
);

  localparam int unsigned OP_W  = 7;
  localparam int unsigned SIG_W = 11;

  localparam logic [OP_W-1:0] OP_ALU   = 7'h33;
  localparam logic [OP_W-1:0] OP_ALUI  = 7'h13;
  localparam logic [OP_W-1:0] OP_LOAD  = 7'h03;
  localparam logic [OP_W-1:0] OP_STORE = 7'h23;
  localparam logic [OP_W-1:0] OP_BR    = 7'h63;
  localparam logic [OP_W-1:0] OP_LUI   = 7'h37;
  localparam logic [OP_W-1:0] OP_AUIPC = 7'h17;
  localparam logic [OP_W-1:0] OP_JAL   = 7'h6F;
  localparam logic [OP_W-1:0] OP_JALR  = 7'h67;

  localparam logic [SIG_W-1:0] W_ALU   = 11'h210;
  localparam logic [SIG_W-1:0] W_ALUI  = 11'h214;
  localparam logic [SIG_W-1:0] W_LOAD  = 11'h03D;
  localparam logic [SIG_W-1:0] W_STORE = 11'h045;
  localparam logic [SIG_W-1:0] W_BR    = 11'h482;
  localparam logic [SIG_W-1:0] W_LUI   = 11'h314;
  localparam logic [SIG_W-1:0] W_AUIPC = 11'h396;
  localparam logic [SIG_W-1:0] W_JAL   = 11'h712;
  localparam logic [SIG_W-1:0] W_JALR  = 11'h715;

  // Per-state gating: Branch only in EXEC, MemRead/MemWrite only in MEM, RegWrite only in WB.
  localparam logic [SIG_W-1:0] MASK_EXEC = 11'h78F;
  localparam logic [SIG_W-1:0] MASK_MEM  = 11'h76F;
  localparam logic [SIG_W-1:0] MASK_WB   = 11'h71F;

  localparam logic [TIMEOUT_W-1:0] WAIT_MAX = '1;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_e;

  state_e               state_q, state_d;
  logic [OP_W-1:0]      op_q, op_d;
  logic [TIMEOUT_W-1:0] wait_q, wait_d;
  logic                 illegal_q, illegal_d;
  logic                 timeout_q, timeout_d;

  logic [SIG_W-1:0]     cls_word;
  logic                 cls_legal;
  logic                 is_load, is_store, is_branch;

  // Opcode class decode of the latched instruction
  always_comb begin
    cls_word  = '0;
    cls_legal = 1'b1;
    case (op_q)
      OP_ALU:   cls_word = W_ALU;
      OP_ALUI:  cls_word = W_ALUI;
      OP_LOAD:  cls_word = W_LOAD;
      OP_STORE: cls_word = W_STORE;
      OP_BR:    cls_word = W_BR;
      OP_LUI:   if (EXT_OPS) cls_word = W_LUI;   else cls_legal = 1'b0;
      OP_AUIPC: if (EXT_OPS) cls_word = W_AUIPC; else cls_legal = 1'b0;
      OP_JAL:   if (EXT_OPS) cls_word = W_JAL;   else cls_legal = 1'b0;
      OP_JALR:  if (EXT_OPS) cls_word = W_JALR;  else cls_legal = 1'b0;
      default:  cls_legal = 1'b0;
    endcase
  end

  assign is_load   = (op_q == OP_LOAD);
  assign is_store  = (op_q == OP_STORE);
  assign is_branch = (op_q == OP_BR);

  // Next-state logic; the wait counter is cleared on every entry to FETCH or MEM
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    wait_d    = wait_q;
    illegal_d = illegal_q;
    timeout_d = timeout_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ready) begin
          op_d    = opcode;
          state_d = S_DECODE;
        end else if (wait_q == WAIT_MAX) begin
          state_d   = S_TRAP;
          timeout_d = 1'b1;
        end else begin
          wait_d = wait_q + TIMEOUT_W'(1);
        end
      end
      S_DECODE: begin
        if (cls_legal) begin
          state_d = S_EXEC;
        end else begin
          state_d   = S_TRAP;
          illegal_d = 1'b1;
        end
      end
      S_EXEC: begin
        if (is_load || is_store) begin
          state_d = S_MEM;
          wait_d  = '0;
        end else if (is_branch) begin
          state_d = S_FETCH;
          wait_d  = '0;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (mem_ready) begin
          if (is_load) begin
            state_d = S_WB;
          end else begin
            state_d = S_FETCH;
            wait_d  = '0;
          end
        end else if (wait_q == WAIT_MAX) begin
          state_d   = S_TRAP;
          timeout_d = 1'b1;
        end else begin
          wait_d = wait_q + TIMEOUT_W'(1);
        end
      end
      S_WB: begin
        state_d = S_FETCH;
        wait_d  = '0;
      end
      S_TRAP: ;
      default: begin
        state_d   = S_TRAP;
        illegal_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      op_q      <= '0;
      wait_q    <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  // Control outputs follow the current state; handshake pulses react to mem_ready in-cycle
  always_comb begin
    signals   = '0;
    fetch_req = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    retire    = 1'b0;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          fetch_req = 1'b1;
          ir_write  = mem_ready;
        end
        S_EXEC: begin
          signals  = cls_word & MASK_EXEC;
          pc_write = is_branch;
          retire   = is_branch;
        end
        S_MEM: begin
          signals  = cls_word & MASK_MEM;
          pc_write = is_store && mem_ready;
          retire   = is_store && mem_ready;
        end
        S_WB: begin
          signals  = cls_word & MASK_WB;
          pc_write = 1'b1;
          retire   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign illegal = illegal_q;
  assign timeout = timeout_q;
  assign state   = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: three configurations (default, EXT_OPS=0, TIMEOUT_W=2)
// share one stimulus stream and are checked each cycle against a behavioural model.
module tb_multicycle_control;

  localparam int NCFG = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_ready;
  logic [6:0]  opcode;

  logic [10:0] sig [NCFG];
  logic        fr  [NCFG];
  logic        irw [NCFG];
  logic        pcw [NCFG];
  logic        ret [NCFG];
  logic        ill [NCFG];
  logic        tmo [NCFG];
  logic [2:0]  st  [NCFG];

  int errors = 0;
  int checks = 0;

  // Model of each configuration: current state number, latched opcode, cycles spent in state
  int m_st  [NCFG];
  int m_op  [NCFG];
  int m_cnt [NCFG];
  bit m_ill [NCFG];
  bit m_tmo [NCFG];

  always #5 clk = ~clk;

  multicycle_control #(.EXT_OPS(1'b1), .TIMEOUT_W(4)) dut0 (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .signals(sig[0]), .fetch_req(fr[0]), .ir_write(irw[0]), .pc_write(pcw[0]),
    .retire(ret[0]), .illegal(ill[0]), .timeout(tmo[0]), .state(st[0]));

  multicycle_control #(.EXT_OPS(1'b0), .TIMEOUT_W(4)) dut1 (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .signals(sig[1]), .fetch_req(fr[1]), .ir_write(irw[1]), .pc_write(pcw[1]),
    .retire(ret[1]), .illegal(ill[1]), .timeout(tmo[1]), .state(st[1]));

  multicycle_control #(.EXT_OPS(1'b1), .TIMEOUT_W(2)) dut2 (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .signals(sig[2]), .fetch_req(fr[2]), .ir_write(irw[2]), .pc_write(pcw[2]),
    .retire(ret[2]), .illegal(ill[2]), .timeout(tmo[2]), .state(st[2]));

  function automatic bit cfg_ext(input int k);
    return k != 1;
  endfunction

  function automatic int cfg_lim(input int k);
    return (k == 2) ? 3 : 15;
  endfunction

  // Class word for an opcode, -1 when the opcode is not decodable
  function automatic int word_of(input int op, input bit ext);
    case (op)
      'h33: return 'h210;
      'h13: return 'h214;
      'h03: return 'h03D;
      'h23: return 'h045;
      'h63: return 'h482;
      'h37: return ext ? 'h314 : -1;
      'h17: return ext ? 'h396 : -1;
      'h6F: return ext ? 'h712 : -1;
      'h67: return ext ? 'h715 : -1;
      default: return -1;
    endcase
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, want, $time);
    end
  endtask

  // Compare every output of every configuration with the model
  task automatic check_all();
    for (int k = 0; k < NCFG; k++) begin
      int w;
      logic [31:0] e_sig;
      bit e_fr, e_ir, e_pc;
      w = word_of(m_op[k], cfg_ext(k));
      e_sig = '0; e_fr = 0; e_ir = 0; e_pc = 0;
      if (!reset) begin
        case (m_st[k])
          0: begin e_fr = 1; e_ir = mem_ready; end
          2: begin e_sig = (w & 'h70F) | (w & 'h080); e_pc = (w == 'h482); end
          3: begin e_sig = (w & 'h70F) | (w & 'h060); e_pc = (w == 'h045) && mem_ready; end
          4: begin e_sig = (w & 'h70F) | (w & 'h010); e_pc = 1; end
          default: ;
        endcase
      end
      cmp($sformatf("c%0d state", k),     32'(st[k]),  32'(m_st[k]));
      cmp($sformatf("c%0d signals", k),   32'(sig[k]), e_sig);
      cmp($sformatf("c%0d fetch_req", k), 32'(fr[k]),  32'(e_fr));
      cmp($sformatf("c%0d ir_write", k),  32'(irw[k]), 32'(e_ir));
      cmp($sformatf("c%0d pc_write", k),  32'(pcw[k]), 32'(e_pc));
      cmp($sformatf("c%0d retire", k),    32'(ret[k]), 32'(e_pc));
      cmp($sformatf("c%0d illegal", k),   32'(ill[k]), 32'(m_ill[k]));
      cmp($sformatf("c%0d timeout", k),   32'(tmo[k]), 32'(m_tmo[k]));
    end
  endtask

  // Advance the model across one rising edge using the inputs held at that edge
  task automatic model_step();
    for (int k = 0; k < NCFG; k++) begin
      int s, ns, w, lim;
      s   = m_st[k];
      w   = word_of(m_op[k], cfg_ext(k));
      lim = cfg_lim(k);
      if (reset) begin
        m_st[k] = 0; m_op[k] = 0; m_cnt[k] = 0; m_ill[k] = 0; m_tmo[k] = 0;
        continue;
      end
      ns = s;
      case (s)
        0: if (mem_ready) begin m_op[k] = int'(opcode); ns = 1; end
           else if (m_cnt[k] == lim) begin ns = 5; m_tmo[k] = 1; end
        1: if (w < 0) begin ns = 5; m_ill[k] = 1; end else ns = 2;
        2: ns = (w == 'h03D || w == 'h045) ? 3 : (w == 'h482) ? 0 : 4;
        3: if (mem_ready) ns = (w == 'h03D) ? 4 : 0;
           else if (m_cnt[k] == lim) begin ns = 5; m_tmo[k] = 1; end
        4: ns = 0;
        default: ns = 5;
      endcase
      m_cnt[k] = (ns == s) ? m_cnt[k] + 1 : 0;
      m_st[k]  = ns;
    end
  endtask

  task automatic drive(input bit r, input bit mr, input logic [6:0] op);
    @(negedge clk);
    reset = r; mem_ready = mr; opcode = op;
    #1;
    check_all();
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
  endtask

  // Hand-computed expectations for one configuration at the current sample point
  task automatic lit(input int k, input int est, input int esig, input int eret, input int efr);
    cmp($sformatf("lit c%0d state", k),     32'(st[k]),  32'(est));
    cmp($sformatf("lit c%0d signals", k),   32'(sig[k]), 32'(esig));
    cmp($sformatf("lit c%0d retire", k),    32'(ret[k]), 32'(eret));
    cmp($sformatf("lit c%0d fetch_req", k), 32'(fr[k]),  32'(efr));
  endtask

  logic [6:0] ops_tab [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67};

  initial begin
    int trap_run;
    int pct;
    reset = 1'b1; mem_ready = 1'b0; opcode = '0;
    tick();

    // ALU instruction with no stalls, twice; reset cycle keeps everything quiet
    drive(1, 1, 7'h33); lit(0, 0, 0, 0, 0); tick();
    drive(0, 1, 7'h33); lit(0, 0, 0, 0, 1); tick();
    drive(0, 1, 7'h33); lit(0, 1, 0, 0, 0); tick();
    drive(0, 1, 7'h33); lit(0, 2, 'h200, 0, 0); tick();
    drive(0, 1, 7'h33); lit(0, 4, 'h210, 1, 0); tick();
    drive(0, 1, 7'h33); lit(0, 0, 0, 0, 1); tick();
    drive(0, 1, 7'h33); lit(0, 1, 0, 0, 0); tick();
    drive(0, 1, 7'h33); lit(0, 2, 'h200, 0, 0); tick();
    drive(0, 1, 7'h33); lit(0, 4, 'h210, 1, 0); tick();

    // Load with three MEM stall cycles
    drive(0, 1, 7'h03); lit(0, 0, 0, 0, 1); tick();
    drive(0, 0, 7'h03); lit(0, 1, 0, 0, 0); tick();
    drive(0, 0, 7'h03); lit(0, 2, 'h00D, 0, 0); tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 7'h03); lit(0, 3, 'h02D, 0, 0); tick();
    end
    drive(0, 1, 7'h03); lit(0, 3, 'h02D, 0, 0); tick();
    drive(0, 1, 7'h03); lit(0, 4, 'h01D, 1, 0); tick();

    // Store retires in MEM, no WB
    drive(0, 1, 7'h23); lit(0, 0, 0, 0, 1); tick();
    drive(0, 1, 7'h23); lit(0, 1, 0, 0, 0); tick();
    drive(0, 0, 7'h23); lit(0, 2, 'h005, 0, 0); tick();
    drive(0, 0, 7'h23); lit(0, 3, 'h045, 0, 0); tick();
    drive(0, 1, 7'h23); lit(0, 3, 'h045, 1, 0); cmp("store pc_write", 32'(pcw[0]), 1); tick();
    drive(0, 0, 7'h23); lit(0, 0, 0, 0, 1); tick();

    // JAL: legal with extensions, trapped without
    drive(0, 1, 7'h6F); lit(0, 0, 0, 0, 1); tick();
    drive(0, 0, 7'h6F); lit(0, 1, 0, 0, 0); lit(1, 1, 0, 0, 0); tick();
    drive(0, 0, 7'h6F); lit(0, 2, 'h702, 0, 0); lit(1, 5, 0, 0, 0);
    cmp("jal illegal c1", 32'(ill[1]), 1); cmp("jal illegal c0", 32'(ill[0]), 0); tick();
    drive(0, 0, 7'h6F); lit(0, 4, 'h712, 1, 0); lit(1, 5, 0, 0, 0); tick();
    drive(0, 1, 7'h6F); lit(0, 0, 0, 0, 1); lit(1, 5, 0, 0, 0);
    cmp("trap ir_write c1", 32'(irw[1]), 0); tick();

    // Fetch watchdog with a 2-bit counter: timeout, then ready on the last allowed cycle
    drive(1, 0, 7'h00); tick();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 7'h00); lit(2, 0, 0, 0, 1); tick();
    end
    drive(0, 0, 7'h00); lit(2, 5, 0, 0, 0); lit(0, 0, 0, 0, 1);
    cmp("timeout c2", 32'(tmo[2]), 1); cmp("timeout c0", 32'(tmo[0]), 0); tick();
    drive(1, 0, 7'h00); cmp("timeout held c2", 32'(tmo[2]), 1); tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 7'h33); lit(2, 0, 0, 0, 1); tick();
    end
    drive(0, 1, 7'h33); lit(2, 0, 0, 0, 1); cmp("late ready ir_write c2", 32'(irw[2]), 1); tick();
    drive(0, 0, 7'h33); lit(2, 1, 0, 0, 0); cmp("late ready timeout c2", 32'(tmo[2]), 0); tick();

    // Reset in the middle of a store's MEM wait
    drive(1, 0, 7'h23); tick();
    drive(0, 1, 7'h23); tick();
    drive(0, 0, 7'h23); tick();
    drive(0, 0, 7'h23); tick();
    drive(0, 0, 7'h23); lit(0, 3, 'h045, 0, 0); tick();
    drive(1, 1, 7'h23); lit(0, 3, 0, 0, 0); tick();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 7'h23); lit(0, 0, 0, 0, 1); cmp("no pc_write after reset", 32'(pcw[0]), 0); tick();
    end

    // Randomized traffic across three memory-readiness regimes
    trap_run = 0;
    pct = 90;
    for (int n = 0; n < 3000; n++) begin
      int pick;
      bit r;
      logic [6:0] op;
      if (n % 500 == 0) pct = ((n / 500) % 3 == 0) ? 90 : ((n / 500) % 3 == 1) ? 55 : 30;
      pick = int'($urandom_range(0, 11));
      op = (pick < 9) ? ops_tab[pick] : 7'($urandom_range(0, 127));
      if (m_st[0] == 5 || m_st[1] == 5 || m_st[2] == 5) trap_run++;
      else trap_run = 0;
      r = (trap_run > 3) || ($urandom_range(0, 199) == 0);
      if (r) trap_run = 0;
      drive(r, int'($urandom_range(0, 99)) < pct, op);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter EXT_OPS, default 1, meaning: 1 enables decode of LUI/AUIPC/JAL/JALR; 0 treats them as illegal.
REQ-002 Parameter TIMEOUT_W, default 4, meaning: width of the memory-wait counter; timeout limit is 2^TIMEOUT_W-1 cycles.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 opcode  input  7  instruction opcode field, sampled only on fetch completion.
REQ-006 mem_ready  input  1  memory handshake: access completes in the cycle it is 1.
REQ-007 signals  output  11  control bundle: [1:0] imm sel, [2] AluSrc, [3] MemToReg, [4] RegWrite, [5] MemRead, [6] MemWrite, [7] Branch, [10:8] AluOP.
REQ-008 fetch_req  output  1  instruction-memory read request.
REQ-009 ir_write  output  1  one-cycle pulse that loads the instruction register.
REQ-010 pc_write  output  1  one-cycle pulse that advances or redirects the PC.
REQ-011 retire  output  1  one-cycle pulse per completed instruction.
REQ-012 illegal  output  1  sticky: undecodable opcode trapped.
REQ-013 timeout  output  1  sticky: memory wait exceeded limit.
REQ-014 state  output  3  current state encoding, for debug.

Function
REQ-015 States and encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5; values 6 and 7 are unreachable and go to TRAP with illegal=1.
REQ-016 Class words (registered opcode op_q): 0x33 -> 0x210; 0x13 -> 0x214; 0x03 -> 0x03D; 0x23 -> 0x045; 0x63 -> 0x482.
REQ-017 Class words when EXT_OPS=1: 0x37 -> 0x314; 0x17 -> 0x396; 0x6F -> 0x712; 0x67 -> 0x715.
REQ-018 All other opcodes are illegal.
REQ-019 signals=0 in FETCH, DECODE and TRAP.
REQ-020 In EXEC, MEM and WB, signals equals the class word with bit7 gated to EXEC only, bits 5 and 6 gated to MEM only, and bit4 gated to WB only.
REQ-021 FETCH: fetch_req=1 each cycle.
REQ-022 FETCH with mem_ready=1: pulse ir_write, load op_q<=opcode, go to DECODE.
REQ-023 DECODE: lasts one cycle; a legal op_q goes to EXEC, an illegal op_q goes to TRAP and sets illegal.
REQ-024 EXEC, load or store class: go to MEM.
REQ-025 EXEC, branch class: pulse pc_write and retire, then go to FETCH.
REQ-026 EXEC, all other classes: go to WB.
REQ-027 MEM: hold until mem_ready=1.
REQ-028 MEM with mem_ready=1: a load goes to WB; a store pulses pc_write and retire, then goes to FETCH.
REQ-029 WB: lasts one cycle, pulses pc_write and retire, then goes to FETCH.
REQ-030 Wait counter: cleared on entry to FETCH or MEM, incremented each cycle spent waiting with mem_ready=0.
REQ-031 When the wait counter equals 2^TIMEOUT_W-1 and mem_ready=0, go to TRAP and set timeout.
REQ-032 If mem_ready=1 in the same cycle the counter equals its limit, the access completes; mem_ready wins.
REQ-033 TRAP: absorbing; all pulses and signals are 0, and illegal/timeout hold until reset.
REQ-034 Latency without memory stalls: ALU/LUI/AUIPC/JAL/JALR take 4 cycles, load 5, store 4, branch 3 (FETCH to retire inclusive).
REQ-035 Pulse outputs (ir_write, pc_write, retire) are asserted for exactly one cycle and never in consecutive cycles.

Reset
REQ-036 reset=1 at a clock edge forces state=FETCH, op_q=0, wait counter=0, illegal=0 and timeout=0, from any state including TRAP and mid-MEM.
REQ-037 While reset=1: signals=0, ir_write=0, pc_write=0, retire=0, and fetch_req=0.
REQ-038 In the first cycle after reset deasserts: fetch_req=1.

Verification
REQ-039 Scenario 1: mem_ready held 1, opcode=0x33 -> states 0,1,2,4; signals 0,0,0x200,0x210; retire in the 4th cycle; pattern repeats.
REQ-040 Scenario 2: opcode=0x03, mem_ready=0 for 3 MEM cycles then 1 -> MEM holds signals=0x02D for 4 cycles, then WB signals=0x01D with retire.
REQ-041 Scenario 3: opcode=0x23 -> MEM signals=0x045, retire and pc_write on the MEM cycle where mem_ready=1; no WB state.
REQ-042 Scenario 4: opcode=0x6F with EXT_OPS=0 -> TRAP after DECODE with illegal=1; with EXT_OPS=1 -> WB signals=0x712.
REQ-043 Scenario 5: TIMEOUT_W=2, mem_ready=0 in FETCH -> TRAP with timeout=1 after 4 FETCH cycles; mem_ready=1 on the 4th cycle gives DECODE instead.
REQ-044 Scenario 6: reset pulse during MEM of a store -> no MemWrite afterwards, state=0, and no retire.
